// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle between WB stage, long-latency unit, hazard unit
// and the write-port arbiter.
interface wb_port_arbiter_if #(
  parameter int DEPTH = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             pipe_wr_en;
  logic [4:0]       pipe_wr_reg;
  logic [31:0]      pipe_wr_data;
  logic             lu_valid;
  logic [4:0]       lu_reg;
  logic [31:0]      lu_data;
  logic             lu_ready;
  logic [4:0]       chk_reg;
  logic             chk_busy;
  logic             stall_pipe;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [31:0]      rf_wdata;
  logic [CNT_W-1:0] pend_count;
  logic             proto_err;

  modport slave (
    input  pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    input  lu_valid, lu_reg, lu_data,
    output lu_ready,
    input  chk_reg,
    output chk_busy, stall_pipe,
    output rf_we, rf_waddr, rf_wdata,
    output pend_count, proto_err
  );

  modport master (
    output pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    output lu_valid, lu_reg, lu_data,
    input  lu_ready,
    output chk_reg,
    input  chk_busy, stall_pipe,
    input  rf_we, rf_waddr, rf_wdata,
    input  pend_count, proto_err
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the WB stage and a long-latency unit,
// parking long-unit results in a small FIFO that drains on idle port cycles.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  wb_port_arbiter_if.slave  bus
);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic [4:0]        fifoReg  [DEPTH];
  logic [31:0]       fifoData [DEPTH];
  logic [DEPTH-1:0]  fifoVld;
  logic [PTR_W-1:0]  rdPtr, wrPtr;
  logic [CNT_W-1:0]  count;
  logic [WAIT_W-1:0] waitCnt;
  logic              stallPipe, protoErr;

  logic headPresent, headValid, luReady, luAcc, luNonZero;
  logic pipeAct, pop, bypass, luDup, push;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Port grant: pipeline first, then FIFO head, then direct bypass of the long unit
  always_comb begin
    headPresent = (count != '0);
    headValid   = fifoVld[rdPtr];
    luReady     = (count < CNT_W'(DEPTH));
    luAcc       = bus.lu_valid & luReady;
    luNonZero   = (bus.lu_reg != 5'd0);
    pipeAct     = bus.pipe_wr_en & ~stallPipe & (bus.pipe_wr_reg != 5'd0);
    pop         = ~pipeAct & headPresent;
    bypass      = ~pipeAct & ~headPresent & luAcc & luNonZero;
    luDup       = pipeAct & (bus.lu_reg == bus.pipe_wr_reg);
    push        = luAcc & luNonZero & ~bypass & ~luDup;
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = 5'd0;
    bus.rf_wdata = 32'd0;
    if (!rst) begin
      if (pipeAct) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.pipe_wr_reg;
        bus.rf_wdata = bus.pipe_wr_data;
      end else if (pop && headValid) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = fifoReg[rdPtr];
        bus.rf_wdata = fifoData[rdPtr];
      end else if (bypass) begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.lu_reg;
        bus.rf_wdata = bus.lu_data;
      end
    end
  end

  // fifoVld is cleared on pop, so it alone marks live, unkilled entries
  always_comb begin
    bus.chk_busy = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (fifoVld[i] && (fifoReg[i] == bus.chk_reg) && (bus.chk_reg != 5'd0))
        bus.chk_busy = 1'b1;
    end
  end

  assign bus.lu_ready   = luReady;
  assign bus.stall_pipe = stallPipe;
  assign bus.pend_count = count;
  assign bus.proto_err  = protoErr;

  always_ff @(posedge clk) begin
    if (rst) begin
      fifoVld   <= '0;
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      waitCnt   <= '0;
      stallPipe <= 1'b0;
      protoErr  <= 1'b0;
    end else begin
      // A pipeline write is younger than any parked result to the same register
      for (int i = 0; i < DEPTH; i++) begin
        if (pipeAct && fifoVld[i] && (fifoReg[i] == bus.pipe_wr_reg))
          fifoVld[i] <= 1'b0;
      end
      if (pop) begin
        fifoVld[rdPtr] <= 1'b0;
        rdPtr          <= ptrInc(rdPtr);
      end
      if (push) begin
        fifoVld[wrPtr] <= 1'b1;
        wrPtr          <= ptrInc(wrPtr);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (pop || !headPresent)
        waitCnt <= '0;
      else if (headValid && (waitCnt < WAIT_W'(MAX_WAIT)))
        waitCnt <= waitCnt + WAIT_W'(1);

      if (pop)
        stallPipe <= 1'b0;
      else if (headValid && (waitCnt >= WAIT_W'(MAX_WAIT)))
        stallPipe <= 1'b1;

      if (bus.pipe_wr_en && stallPipe)
        protoErr <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifoReg[wrPtr]  <= bus.lu_reg;
      fifoData[wrPtr] <= bus.lu_data;
    end
  end
endmodule
